// File: rtl/pcie_qos_pkg.sv
// Shared constants and types for the PCIe QoS VC datapath.
// Word geometry and hold-slot state encoding.
package pcie_qos_pkg;

  localparam int DATA_W   = 6;
  localparam int VCID_BIT = 4;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/vc_hold_slot.sv
// One-entry retry hold for a single VC FIFO write port.
// Registers push/data and keeps a saturating push counter.
module vc_hold_slot #(
  parameter int DATA_W = pcie_qos_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_new,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_full,
  output logic              o_push,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_drop
);
  import pcie_qos_pkg::*;

  hold_state_t       r_state;
  hold_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] w_hold_nxt;
  logic              r_push;
  logic              w_push_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic [CNT_W-1:0]  r_count;
  logic              w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_push_nxt  = 1'b0;
    w_data_nxt  = '0;
    w_drop      = 1'b0;
    unique case (r_state)
      HOLD_EMPTY: begin
        if (i_new && !i_full) begin
          w_push_nxt = 1'b1;
          w_data_nxt = i_data;
        end else if (i_new) begin
          w_hold_nxt  = i_data;
          w_state_nxt = HOLD_HELD;
        end
      end
      HOLD_HELD: begin
        // Held word always goes first so VC order is preserved.
        if (!i_full) begin
          w_push_nxt = 1'b1;
          w_data_nxt = r_hold;
          if (i_new) begin
            w_hold_nxt = i_data;
          end else begin
            w_state_nxt = HOLD_EMPTY;
          end
        end else if (i_new) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HOLD_EMPTY;
      r_hold  <= '0;
      r_push  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_push  <= w_push_nxt;
      r_data  <= w_data_nxt;
      if (w_push_nxt && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_push  = r_push;
  assign o_data  = r_data;
  assign o_count = r_count;
  assign o_drop  = w_drop;

endmodule

// File: rtl/vcid_demux_stage.sv
// Routes popped Main FIFO words to the VC0/VC1 FIFO write ports
// by one VCID bit, with per-VC retry hold and drop statistics.
module vcid_demux_stage #(
  parameter int DATA_W   = pcie_qos_pkg::DATA_W,
  parameter int VCID_BIT = pcie_qos_pkg::VCID_BIT,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] demux_vcid_in,
  input  logic              demux_vcid_valid_in,
  input  logic              VC0_full,
  input  logic              VC1_full,
  output logic [DATA_W-1:0] VC0_data_in,
  output logic              VC0_push,
  output logic [DATA_W-1:0] VC1_data_in,
  output logic              VC1_push,
  output logic [CNT_W-1:0]  VC0_count,
  output logic [CNT_W-1:0]  VC1_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow_err
);

  logic             w_tgt;
  logic             w_new0;
  logic             w_new1;
  logic             w_drop0;
  logic             w_drop1;
  logic [CNT_W-1:0] r_drop_count;
  logic             r_ovf;

  assign w_tgt  = demux_vcid_in[VCID_BIT];
  assign w_new0 = demux_vcid_valid_in && !w_tgt;
  assign w_new1 = demux_vcid_valid_in && w_tgt;

  vc_hold_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_vc0 (
    .clk     (clk),
    .reset   (reset),
    .i_new   (w_new0),
    .i_data  (demux_vcid_in),
    .i_full  (VC0_full),
    .o_push  (VC0_push),
    .o_data  (VC0_data_in),
    .o_count (VC0_count),
    .o_drop  (w_drop0)
  );

  vc_hold_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_vc1 (
    .clk     (clk),
    .reset   (reset),
    .i_new   (w_new1),
    .i_data  (demux_vcid_in),
    .i_full  (VC1_full),
    .o_push  (VC1_push),
    .o_data  (VC1_data_in),
    .o_count (VC1_count),
    .o_drop  (w_drop1)
  );

  // Only one new word per cycle, so at most one slot can drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= '0;
      r_ovf        <= 1'b0;
    end else if (w_drop0 || w_drop1) begin
      r_ovf <= 1'b1;
      if (r_drop_count != '1) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end
  end

  assign drop_count   = r_drop_count;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_vcid_demux_stage.sv
// Directed bench for vcid_demux_stage with a queue-level
// reference model compared on every falling edge.
module tb_vcid_demux_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] din = '0;
  logic       vin = 1'b0;
  logic       f0 = 1'b0;
  logic       f1 = 1'b0;
  logic [5:0] d0, d1;
  logic       p0, p1;
  logic [7:0] c0, c1, dc;
  logic       ovf;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vcid_demux_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .demux_vcid_in       (din),
    .demux_vcid_valid_in (vin),
    .VC0_full            (f0),
    .VC1_full            (f1),
    .VC0_data_in         (d0),
    .VC0_push            (p0),
    .VC1_data_in         (d1),
    .VC1_push            (p1),
    .VC0_count           (c0),
    .VC1_count           (c1),
    .drop_count          (dc),
    .overflow_err        (ovf)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) t=%0t",
                  nm, act, act, exp, exp, $time);
  endtask

  // Model: each VC owns a pending list of at most one word.
  int         qn[2];
  logic [5:0] qd[2];
  int         e_push[2];
  int         e_data[2];
  int         e_cnt[2];
  int         e_drop;
  int         e_ovf;
  bit         live = 0;

  always @(posedge clk) begin
    if (reset) begin
      live = 1;
      e_drop = 0;
      e_ovf = 0;
      for (int v = 0; v < 2; v++) begin
        qn[v] = 0; qd[v] = '0;
        e_push[v] = 0; e_data[v] = 0; e_cnt[v] = 0;
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        logic [5:0] lst[2];
        int n;
        bit full;
        n = 0;
        lst[0] = '0; lst[1] = '0;
        if (qn[v] > 0) begin lst[n] = qd[v]; n++; end
        if (vin && (int'(din[4]) == v)) begin lst[n] = din; n++; end
        full = (v == 0) ? f0 : f1;
        e_push[v] = 0;
        e_data[v] = 0;
        if (!full && n > 0) begin
          e_push[v] = 1;
          e_data[v] = lst[0];
          lst[0] = lst[1];
          n--;
          if (e_cnt[v] < 255) e_cnt[v]++;
        end
        if (n > 1) begin
          n = 1;
          e_ovf = 1;
          if (e_drop < 255) e_drop++;
        end
        qn[v] = n;
        qd[v] = lst[0];
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("m_push0", int'(p0), e_push[0]);
      check("m_data0", int'(d0), e_data[0]);
      check("m_push1", int'(p1), e_push[1]);
      check("m_data1", int'(d1), e_data[1]);
      check("m_cnt0", int'(c0), e_cnt[0]);
      check("m_cnt1", int'(c1), e_cnt[1]);
      check("m_drop", int'(dc), e_drop);
      check("m_ovf", int'(ovf), e_ovf);
    end
  end

  // Apply inputs for one decision; returns after outputs reflect it.
  task automatic drive(input logic v, input logic [5:0] d,
                       input logic a0, input logic a1);
    vin = v; din = d; f0 = a0; f1 = a1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with a valid word present
    @(negedge clk); #1;
    drive(1, 6'h15, 0, 0);
    drive(1, 6'h15, 0, 0);
    check("rst_push0", int'(p0), 0);
    check("rst_push1", int'(p1), 0);
    check("rst_data1", int'(d1), 0);
    check("rst_ovf", int'(ovf), 0);
    reset = 1'b0;
    drive(0, 6'h00, 0, 0);
    check("rst_cnts", int'(c0) + int'(c1) + int'(dc), 0);

    // 2: basic routing
    drive(1, 6'h05, 0, 0);
    check("r_push0", int'(p0), 1);
    check("r_data0", int'(d0), 6'h05);
    drive(1, 6'h1A, 0, 0);
    check("r_push1", int'(p1), 1);
    check("r_data1", int'(d1), 6'h1A);
    check("r_nopush0", int'(p0), 0);
    drive(0, 6'h00, 0, 0);
    check("r_cnt0", int'(c0), 1);
    check("r_cnt1", int'(c1), 1);

    // 3: retry on VC0
    drive(1, 6'h03, 1, 0);
    check("h_nopush_a", int'(p0), 0);
    drive(0, 6'h00, 1, 0);
    drive(0, 6'h00, 1, 0);
    check("h_nopush_b", int'(p0), 0);
    drive(0, 6'h00, 0, 0);
    check("h_push", int'(p0), 1);
    check("h_data", int'(d0), 6'h03);
    check("h_drop", int'(dc), 0);

    // 4: order and drop on VC1
    drive(1, 6'h11, 0, 1);
    drive(1, 6'h12, 0, 1);
    check("o_drop", int'(dc), 1);
    check("o_ovf", int'(ovf), 1);
    check("o_nopush", int'(p1), 0);
    drive(1, 6'h13, 0, 0);
    check("o_first", int'(d1), 6'h11);
    drive(0, 6'h00, 0, 0);
    check("o_second", int'(d1), 6'h13);
    drive(0, 6'h00, 0, 0);
    check("o_idle", int'(p1), 0);

    // 5: VC0 streams while VC1 is stalled with a held word
    drive(1, 6'h1F, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 6'(i), 0, 1);
      check("i_push", int'(p0), 1);
      check("i_data", int'(d0), i);
    end
    check("i_cnt0", int'(c0), 10);
    check("i_stall1", int'(p1), 0);

    // 6: saturation, then reset while VC1 is held
    for (int i = 0; i < 300; i++) drive(1, 6'(i % 16), 0, 1);
    check("s_cnt0", int'(c0), 255);
    reset = 1'b1;
    drive(0, 6'h00, 0, 0);
    check("s_rst_push1", int'(p1), 0);
    reset = 1'b0;
    drive(0, 6'h00, 0, 0);
    drive(0, 6'h00, 0, 0);
    check("s_nopush1", int'(p1), 0);
    check("s_ovf", int'(ovf), 0);
    check("s_cnt0_clr", int'(c0), 0);
    check("s_drop_clr", int'(dc), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
